// File: rtl/hockey_pkg.sv
// Shared types and default geometry for the air-hockey game engine.
package hockey_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam int SCORE_W = 7;

  localparam int DEF_H_RES        = 640;
  localparam int DEF_V_RES        = 480;
  localparam int DEF_BORDER       = 4;
  localparam int DEF_BALL_SIZE    = 16;
  localparam int DEF_PAD_H        = 64;
  localparam int DEF_PAD_W        = 26;
  localparam int DEF_P1_X         = 33;
  localparam int DEF_P2_X         = 581;
  localparam int DEF_PAD_STEP     = 8;
  localparam int DEF_VX_INIT      = 4;
  localparam int DEF_VX_MAX       = 8;
  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_MISS_FRAMES  = 15;

endpackage

// File: rtl/hockey_core_bcd_score_counter.sv
// Per-player score: BCD ones/tens for display plus a binary total for the win compare.
module bcd_score_counter
  import hockey_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [3:0]         ones,
  output logic [3:0]         tens,
  output logic [SCORE_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones  <= '0;
      tens  <= '0;
      count <= '0;
    end else if (clr) begin
      ones  <= '0;
      tens  <= '0;
      count <= '0;
    end else if (inc) begin
      count <= count + SCORE_W'(1);
      if (ones == 4'd9) begin
        ones <= '0;
        tens <= (tens == 4'd9) ? '0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/hockey_core.sv
// Air-hockey game engine: paddles, ball physics, scoring and match FSM,
// all advancing once per frame_tick.
module hockey_core
  import hockey_pkg::*;
#(
  parameter int H_RES        = DEF_H_RES,
  parameter int V_RES        = DEF_V_RES,
  parameter int BORDER       = DEF_BORDER,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PAD_H        = DEF_PAD_H,
  parameter int PAD_W        = DEF_PAD_W,
  parameter int P1_X         = DEF_P1_X,
  parameter int P2_X         = DEF_P2_X,
  parameter int PAD_STEP     = DEF_PAD_STEP,
  parameter int VX_INIT      = DEF_VX_INIT,
  parameter int VX_MAX       = DEF_VX_MAX,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int MISS_FRAMES  = DEF_MISS_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  input  logic       start,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [8:0] pad1_y,
  output logic [8:0] pad2_y,
  output logic [3:0] p1_ones,
  output logic [3:0] p1_tens,
  output logic [3:0] p2_ones,
  output logic [3:0] p2_tens,
  output logic [2:0] state,
  output logic       miss_flash,
  output logic [1:0] winner
);

  localparam int CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PAD_MAX = V_RES - PAD_H;

  localparam logic [9:0] X_CTR   = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [8:0] Y_CTR   = 9'((V_RES - BALL_SIZE) / 2);
  localparam logic [8:0] PAD_CTR = 9'((V_RES - PAD_H) / 2);

  localparam logic signed [11:0] X_GOAL_L = 12'(BORDER);
  localparam logic signed [11:0] X_GOAL_R = 12'(H_RES - BORDER - BALL_SIZE);
  localparam logic signed [11:0] P1_LO    = 12'(P1_X - BALL_SIZE);
  localparam logic signed [11:0] P1_FACE  = 12'(P1_X + PAD_W);
  localparam logic signed [11:0] P2_LO    = 12'(P2_X - BALL_SIZE);
  localparam logic signed [11:0] P2_HI    = 12'(P2_X + PAD_W);
  localparam logic signed [10:0] Y_MIN    = 11'(BORDER);
  localparam logic signed [10:0] Y_MAX    = 11'(V_RES - BORDER - BALL_SIZE);
  localparam logic signed [10:0] BS_S     = 11'(BALL_SIZE);
  localparam logic signed [10:0] PADH_S   = 11'(PAD_H);

  // Reset: asynchronous assert, deassert released through two flops.
  logic rst_meta, rst_sync_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rst_sync_n, rst_meta} <= 2'b00;
    else        {rst_sync_n, rst_meta} <= {rst_meta, 1'b1};
  end

  // Buttons: {start, p2_dn, p2_up, p1_dn, p1_up}
  logic [4:0] btn_meta, btn_sync;
  logic       start_d, start_pend, start_edge, start_go;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      btn_meta   <= '0;
      btn_sync   <= '0;
      start_d    <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      btn_meta <= {start, p2_dn, p2_up, p1_dn, p1_up};
      btn_sync <= btn_meta;
      start_d  <= btn_sync[4];
      if (frame_tick)      start_pend <= 1'b0;
      else if (start_edge) start_pend <= 1'b1;
    end
  end

  assign start_edge = btn_sync[4] & ~start_d;
  assign start_go   = frame_tick & (start_pend | start_edge);

  state_t           state_q;
  winner_t          winner_q;
  logic [CNT_W-1:0] frame_cnt;
  logic [3:0]       vx;
  logic [2:0]       vy;
  logic             dir_x, dir_y, serve_right, p2_scored;
  logic [SCORE_W-1:0] p1_count, p2_count;

  function automatic logic [8:0] pad_move(input logic [8:0] p, input logic up, input logic dn);
    if (up && !dn) return (p < 9'(PAD_STEP)) ? '0 : p - 9'(PAD_STEP);
    if (dn && !up) return (p > 9'(PAD_MAX - PAD_STEP)) ? 9'(PAD_MAX) : p + 9'(PAD_STEP);
    return p;
  endfunction

  logic [8:0]         pad1_nx, pad2_nx;
  logic signed [11:0] nx;
  logic signed [10:0] ny, ny_c;
  logic signed [10:0] pad1_lo, pad1_hi, pad2_lo, pad2_hi;
  logic               goal_l, goal_r, wall_top, wall_bot, hit1, hit2;

  always_comb begin
    pad1_nx  = pad_move(pad1_y, btn_sync[0], btn_sync[1]);
    pad2_nx  = pad_move(pad2_y, btn_sync[2], btn_sync[3]);
    nx       = dir_x ? $signed(12'(ball_x)) + $signed(12'(vx))
                     : $signed(12'(ball_x)) - $signed(12'(vx));
    ny       = dir_y ? $signed(11'(ball_y)) + $signed(11'(vy))
                     : $signed(11'(ball_y)) - $signed(11'(vy));
    goal_l   = nx <= X_GOAL_L;
    goal_r   = nx >= X_GOAL_R;
    wall_top = ny <= Y_MIN;
    wall_bot = ny >= Y_MAX;
    ny_c     = wall_top ? Y_MIN : (wall_bot ? Y_MAX : ny);
    // Overlap of half-open spans, tested on the wall-clamped y against last frame's paddles.
    pad1_lo  = $signed(11'(pad1_y)) - BS_S;
    pad1_hi  = $signed(11'(pad1_y)) + PADH_S;
    pad2_lo  = $signed(11'(pad2_y)) - BS_S;
    pad2_hi  = $signed(11'(pad2_y)) + PADH_S;
    hit1     = !dir_x && (nx > P1_LO) && (nx < P1_FACE) && (ny_c > pad1_lo) && (ny_c < pad1_hi);
    hit2     =  dir_x && (nx > P2_LO) && (nx < P2_HI)   && (ny_c > pad2_lo) && (ny_c < pad2_hi);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= IDLE;
      winner_q    <= WIN_NONE;
      frame_cnt   <= '0;
      ball_x      <= X_CTR;
      ball_y      <= Y_CTR;
      pad1_y      <= PAD_CTR;
      pad2_y      <= PAD_CTR;
      vx          <= 4'(VX_INIT);
      vy          <= 3'd2;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      serve_right <= 1'b1;
      p2_scored   <= 1'b0;
      miss_flash  <= 1'b0;
    end else if (frame_tick) begin
      if (state_q != OVER) begin
        pad1_y <= pad1_nx;
        pad2_y <= pad2_nx;
      end
      if (start_go) begin
        state_q     <= SERVE;
        winner_q    <= WIN_NONE;
        frame_cnt   <= CNT_W'(1);
        ball_x      <= X_CTR;
        ball_y      <= Y_CTR;
        vx          <= 4'(VX_INIT);
        vy          <= 3'd2;
        serve_right <= 1'b1;
        miss_flash  <= 1'b0;
      end else begin
        case (state_q)
          SERVE: begin
            if (frame_cnt >= CNT_W'(SERVE_FRAMES - 1)) begin
              state_q <= PLAY;
              vx      <= 4'(VX_INIT);
              vy      <= 3'd2;
              dir_x   <= serve_right;
              dir_y   <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
          PLAY: begin
            if (goal_l || goal_r) begin
              state_q     <= MISS;
              miss_flash  <= 1'b1;
              frame_cnt   <= CNT_W'(1);
              ball_x      <= goal_l ? 10'(BORDER) : 10'(H_RES - BORDER - BALL_SIZE);
              p2_scored   <= goal_l;
              serve_right <= goal_r;
            end else begin
              ball_y <= ny_c[8:0];
              if (hit1)      ball_x <= 10'(P1_X + PAD_W);
              else if (hit2) ball_x <= 10'(P2_X - BALL_SIZE);
              else           ball_x <= nx[9:0];
              if (hit1 || hit2) begin
                dir_x <= ~dir_x;
                vx    <= (vx >= 4'(VX_MAX)) ? 4'(VX_MAX) : vx + 4'd1;
              end
              // A moving paddle's spin overrides the wall bounce direction.
              if (hit1 && pad1_nx != pad1_y) begin
                vy    <= (vy >= 3'd2) ? 3'd4 : vy + 3'd2;
                dir_y <= pad1_nx > pad1_y;
              end else if (hit2 && pad2_nx != pad2_y) begin
                vy    <= (vy >= 3'd2) ? 3'd4 : vy + 3'd2;
                dir_y <= pad2_nx > pad2_y;
              end else if (wall_top) begin
                dir_y <= 1'b1;
              end else if (wall_bot) begin
                dir_y <= 1'b0;
              end
            end
          end
          MISS: begin
            if (frame_cnt >= CNT_W'(MISS_FRAMES - 1)) begin
              miss_flash <= 1'b0;
              if (p2_scored ? (p2_count == SCORE_W'(WIN_SCORE)) : (p1_count == SCORE_W'(WIN_SCORE))) begin
                state_q  <= OVER;
                winner_q <= p2_scored ? WIN_P2 : WIN_P1;
              end else begin
                state_q   <= SERVE;
                frame_cnt <= CNT_W'(1);
                ball_x    <= X_CTR;
                ball_y    <= Y_CTR;
              end
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic p1_inc, p2_inc;
  assign p1_inc = frame_tick && !start_go && (state_q == PLAY) && !goal_l && goal_r;
  assign p2_inc = frame_tick && !start_go && (state_q == PLAY) && goal_l;

  bcd_score_counter u_score_p1 (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .clr   (start_go),
    .inc   (p1_inc),
    .ones  (p1_ones),
    .tens  (p1_tens),
    .count (p1_count)
  );

  bcd_score_counter u_score_p2 (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .clr   (start_go),
    .inc   (p2_inc),
    .ones  (p2_ones),
    .tens  (p2_tens),
    .count (p2_count)
  );

  assign state  = state_q;
  assign winner = winner_q;

endmodule
